// File: rtl/pipeline_exec_ctrl_pkg.sv
// Shared definitions for the execution sequencer.
// Used by the debug unit, the sequencer RTL and its testbench.
//   cmd_e   : debug command codes carried on i_cmd
//   state_e : sequencer state encoding, also exported on o_state
package pipeline_exec_ctrl_pkg;

    // Pipeline depth behind decode (ID->EX->MEM->WB).
    localparam int DRAIN_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_STOP = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/pipeline_exec_ctrl_if.sv
// Debug command handshake between the debug unit and the sequencer.
//   i_cmd_valid : debug unit presents a command
//   i_cmd       : command code (see cmd_e)
//   o_cmd_ready : sequencer accepts a command this cycle
// master = debug unit, slave = sequencer.
interface pipeline_exec_ctrl_if;
    logic       i_cmd_valid;
    logic [1:0] i_cmd;
    logic       o_cmd_ready;

    modport master (output i_cmd_valid, output i_cmd, input o_cmd_ready);
    modport slave  (input i_cmd_valid, input i_cmd, output o_cmd_ready);
endinterface

// File: rtl/pipeline_exec_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk, i_reset (async, active-low)
//   i_en    : count up by one this cycle
//   i_clr   : synchronous clear, overrides i_en
//   o_count : current value, holds at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else if (i_en && (o_count != {W{1'b1}})) begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples pre-edge values regardless of block ordering.
            o_count <= o_count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Execution sequencer for the pipelined MIPS core.
// Drives PC freeze and pipeline advance, takes RUN/STEP/STOP from the
// debug unit, drains in-flight instructions after a decoded HALT and
// counts executed (pipeline-advancing) cycles.
//   clk, i_reset  : clock, async active-low reset
//   cmd           : debug command handshake (slave side)
//   i_halt_instr  : decode stage holds a HALT opcode
//   o_pc_hold     : PC frozen
//   o_pipe_en     : pipeline registers advance
//   o_if_flush    : IF/ID loads a NOP
//   o_running     : RUN, STEP or DRAIN
//   o_done        : one-cycle pulse on entry to DONE
//   o_state       : encoded state for debug readout
//   o_cycle_count : saturating count of cycles with o_pipe_en=1
module pipeline_exec_ctrl
    import pipeline_exec_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int DRAIN_W      = $clog2(DRAIN_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 i_reset,
    pipeline_exec_ctrl_if.slave  cmd,
    input  logic                 i_halt_instr,
    output logic                 o_pc_hold,
    output logic                 o_pipe_en,
    output logic                 o_if_flush,
    output logic                 o_running,
    output logic                 o_done,
    output logic [2:0]           o_state,
    output logic [CNT_W-1:0]     o_cycle_count
);

    state_e             state, state_next;
    logic [DRAIN_W-1:0] drain_cnt, drain_next;
    logic               cmd_ready;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            // DONE is only entered from DRAIN, so this marks its first cycle.
            o_done    <= (state == ST_DRAIN) && (state_next == ST_DONE);
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned and infers a latch.
        state_next = state;
        drain_next = drain_cnt;
        o_pc_hold  = 1'b1;
        o_pipe_en  = 1'b0;
        o_if_flush = 1'b0;
        o_running  = 1'b0;
        cmd_ready  = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd.i_cmd_valid) begin
                    if (cmd.i_cmd == CMD_RUN)  state_next = ST_RUN;
                    if (cmd.i_cmd == CMD_STEP) state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                o_pc_hold = 1'b0;
                o_pipe_en = 1'b1;
                o_running = 1'b1;
                cmd_ready = 1'b1;
                // HALT wins over a simultaneous STOP; the STOP is consumed.
                if (i_halt_instr) begin
                    state_next = ST_DRAIN;
                    drain_next = DRAIN_W'(DRAIN_CYCLES);
                end else if (cmd.i_cmd_valid && (cmd.i_cmd == CMD_STOP)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                o_pc_hold = 1'b0;
                o_pipe_en = 1'b1;
                o_running = 1'b1;
                if (i_halt_instr) begin
                    state_next = ST_DRAIN;
                    drain_next = DRAIN_W'(DRAIN_CYCLES);
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                o_pipe_en  = 1'b1;
                o_if_flush = 1'b1;
                o_running  = 1'b1;
                drain_next = drain_cnt - DRAIN_W'(1);
                if (drain_cnt == DRAIN_W'(1)) state_next = ST_DONE;
            end
            ST_DONE: begin
                cmd_ready = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
                drain_next = '0;
            end
        endcase
    end

    assign cmd.o_cmd_ready = cmd_ready;
    assign o_state         = state;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .i_reset (i_reset),
        .i_en    (o_pipe_en),
        .i_clr   (1'b0),
        .o_count (o_cycle_count)
    );

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed testbench for pipeline_exec_ctrl (default build plus a
// CNT_W=4 build for counter saturation).
module tb_pipeline_exec_ctrl;
    import pipeline_exec_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Main DUT
    logic        rst_a, halt_a;
    logic        pc_hold_a, pipe_en_a, if_flush_a, running_a, done_a;
    logic [2:0]  state_a;
    logic [31:0] count_a;
    pipeline_exec_ctrl_if bus_a ();

    pipeline_exec_ctrl u_dut (
        .clk           (clk),
        .i_reset       (rst_a),
        .cmd           (bus_a.slave),
        .i_halt_instr  (halt_a),
        .o_pc_hold     (pc_hold_a),
        .o_pipe_en     (pipe_en_a),
        .o_if_flush    (if_flush_a),
        .o_running     (running_a),
        .o_done        (done_a),
        .o_state       (state_a),
        .o_cycle_count (count_a)
    );

    // Narrow-counter DUT
    logic        rst_b, halt_b;
    logic        pc_hold_b, pipe_en_b, if_flush_b, running_b, done_b;
    logic [2:0]  state_b;
    logic [3:0]  count_b;
    pipeline_exec_ctrl_if bus_b ();

    pipeline_exec_ctrl #(.CNT_W(4)) u_dut4 (
        .clk           (clk),
        .i_reset       (rst_b),
        .cmd           (bus_b.slave),
        .i_halt_instr  (halt_b),
        .o_pc_hold     (pc_hold_b),
        .o_pipe_en     (pipe_en_b),
        .o_if_flush    (if_flush_b),
        .o_running     (running_b),
        .o_done        (done_b),
        .o_state       (state_b),
        .o_cycle_count (count_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input cmd_e c);
        bus_a.i_cmd_valid = v;
        bus_a.i_cmd       = c;
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        #2;
        rst_a = 1'b1;
    endtask

    initial begin
        rst_a = 1'b0; halt_a = 1'b0; send(1'b0, CMD_NOP);
        rst_b = 1'b0; halt_b = 1'b0;
        bus_b.i_cmd_valid = 1'b0; bus_b.i_cmd = CMD_NOP;
        tick();

        // Reset state
        check("rst_state",   32'(state_a),   0);
        check("rst_pc_hold", 32'(pc_hold_a), 1);
        check("rst_pipe_en", 32'(pipe_en_a), 0);
        check("rst_flush",   32'(if_flush_a), 0);
        check("rst_running", 32'(running_a), 0);
        check("rst_ready",   32'(bus_a.o_cmd_ready), 1);
        check("rst_done",    32'(done_a),    0);
        check("rst_count",   count_a,        0);
        rst_a = 1'b1;

        // 1: RUN, HALT in RUN cycle 10, drain, DONE
        send(1'b1, CMD_RUN);
        tick();
        send(1'b0, CMD_NOP);
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("t1_run_pc_hold_%0d", i), 32'(pc_hold_a), 0);
            if (i == 10) halt_a = 1'b1;
            tick();
        end
        halt_a = 1'b0;
        check("t1_drain_count", count_a, 10);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t1_drain_state_%0d", i), 32'(state_a), 3);
            check($sformatf("t1_drain_flush_%0d", i), 32'(if_flush_a), 1);
            check($sformatf("t1_drain_pc_hold_%0d", i), 32'(pc_hold_a), 1);
            check($sformatf("t1_drain_done_%0d", i), 32'(done_a), 0);
            tick();
        end
        check("t1_done_state", 32'(state_a), 4);
        check("t1_done_pulse", 32'(done_a),  1);
        check("t1_count",      count_a,      14);
        tick();
        check("t1_done_pulse_end", 32'(done_a), 0);
        check("t1_pipe_en_off",    32'(pipe_en_a), 0);
        check("t1_count_hold",     count_a, 14);

        // DONE ignores every command
        send(1'b1, CMD_RUN);
        check("done_ready", 32'(bus_a.o_cmd_ready), 1);
        tick();
        check("done_run_state", 32'(state_a), 4);
        send(1'b1, CMD_STEP);
        tick();
        check("done_step_state", 32'(state_a), 4);
        send(1'b0, CMD_NOP);

        // 2: three STEPs from IDLE
        reset_a();
        for (int i = 1; i <= 3; i++) begin
            send(1'b1, CMD_STEP);
            tick();
            send(1'b0, CMD_NOP);
            check($sformatf("t2_step_state_%0d", i), 32'(state_a), 2);
            check($sformatf("t2_step_pc_hold_%0d", i), 32'(pc_hold_a), 0);
            check($sformatf("t2_step_ready_%0d", i), 32'(bus_a.o_cmd_ready), 0);
            tick();
            check($sformatf("t2_idle_state_%0d", i), 32'(state_a), 0);
            check($sformatf("t2_idle_pc_hold_%0d", i), 32'(pc_hold_a), 1);
        end
        check("t2_count", count_a, 3);

        // 3: RUN, STOP in cycle 5, pause, RUN again
        reset_a();
        send(1'b1, CMD_RUN);
        tick();
        send(1'b0, CMD_NOP);
        repeat (4) tick();
        send(1'b1, CMD_STOP);
        tick();
        send(1'b0, CMD_NOP);
        check("t3_stop_state",   32'(state_a),   0);
        check("t3_stop_pc_hold", 32'(pc_hold_a), 1);
        check("t3_stop_count",   count_a,        5);
        repeat (2) tick();
        check("t3_pause_count",  count_a,        5);
        send(1'b1, CMD_RUN);
        tick();
        send(1'b0, CMD_NOP);
        check("t3_resume_state", 32'(state_a), 1);
        tick();
        check("t3_resume_count", count_a, 6);
        check("t3_no_done",      32'(done_a), 0);

        // 4: STOP and HALT together in RUN -> DRAIN
        reset_a();
        send(1'b1, CMD_RUN);
        tick();
        send(1'b1, CMD_STOP);
        halt_a = 1'b1;
        tick();
        send(1'b0, CMD_NOP);
        halt_a = 1'b0;
        check("t4_drain_state", 32'(state_a), 3);
        repeat (3) tick();
        check("t4_still_drain", 32'(state_a), 3);
        tick();
        check("t4_done_state", 32'(state_a), 4);
        check("t4_done_pulse", 32'(done_a),  1);
        check("t4_count",      count_a,      5);

        // 5: async reset two cycles into DRAIN
        reset_a();
        send(1'b1, CMD_RUN);
        tick();
        send(1'b0, CMD_NOP);
        halt_a = 1'b1;
        tick();
        halt_a = 1'b0;
        tick();
        check("t5_pre_state", 32'(state_a), 3);
        rst_a = 1'b0;
        #1;
        check("t5_rst_state",   32'(state_a),   0);
        check("t5_rst_count",   count_a,        0);
        check("t5_rst_done",    32'(done_a),    0);
        check("t5_rst_pc_hold", 32'(pc_hold_a), 1);
        rst_a = 1'b1;
        send(1'b1, CMD_RUN);
        tick();
        send(1'b0, CMD_NOP);
        check("t5_rerun_state", 32'(state_a), 1);
        tick();
        check("t5_rerun_count", count_a, 1);

        // 6: CNT_W=4 saturation
        rst_b = 1'b1;
        bus_b.i_cmd_valid = 1'b1;
        bus_b.i_cmd       = CMD_RUN;
        tick();
        bus_b.i_cmd_valid = 1'b0;
        repeat (15) tick();
        check("t6_count_15", 32'(count_b), 15);
        repeat (5) tick();
        check("t6_count_sat", 32'(count_b), 15);
        check("t6_state",     32'(state_b), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_exec_ctrl.md
Name: pipeline_exec_ctrl

Overview:
Execution sequencer for the pipelined MIPS core. Owns the freeze and advance controls of the PC and the pipeline registers, and accepts RUN/STEP/STOP commands from the debug unit. On a decoded HALT instruction it freezes fetch, drains the in-flight instructions to write-back, then reports completion. It also keeps a saturating count of executed cycles for the debug unit to read.

Parameters:
CNT_W, 32, width of the executed-cycle counter
DRAIN_CYCLES, 4, cycles the pipeline keeps advancing after HALT is decoded (ID->EX->MEM->WB); must be >= 1
DRAIN_W, $clog2(DRAIN_CYCLES+1), width of the drain counter (derived)

Ports:
clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_cmd_valid  in  1  debug unit presents a command
i_cmd  in  2  command: 00 NOP, 01 RUN, 10 STEP, 11 STOP
o_cmd_ready  out  1  controller accepts a command this cycle
i_halt_instr  in  1  decode stage holds a HALT opcode (level, sampled each cycle)
o_pc_hold  out  1  to the PC's i_halt: 1 = PC frozen
o_pipe_en  out  1  pipeline registers advance when 1
o_if_flush  out  1  IF/ID loads a NOP instead of the fetched word
o_running  out  1  state is RUN, STEP or DRAIN
o_done  out  1  one-cycle pulse on entry to DONE
o_state  out  3  encoded state for debug readout
o_cycle_count  out  CNT_W  cycles with o_pipe_en=1 since reset, saturating

Behaviour:
- Registered state machine. Outputs other than o_done and o_cycle_count are decoded combinationally from state (Moore).
- State encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4.
- A command is accepted when i_cmd_valid && o_cmd_ready on a rising edge. A NOP is accepted with no effect.
- Reset (asynchronous, any time, including mid-DRAIN): state=IDLE, drain counter=0, o_cycle_count=0, o_done=0.
- Output values in IDLE after reset: o_pc_hold=1, o_pipe_en=0, o_if_flush=0, o_running=0, o_cmd_ready=1.
- IDLE: PC held, pipeline frozen. o_cmd_ready=1. RUN -> RUN. STEP -> STEP. STOP -> IDLE (no-op).
- RUN: o_pc_hold=0, o_pipe_en=1, o_cmd_ready=1.
  - i_halt_instr=1 -> DRAIN, drain counter loaded with DRAIN_CYCLES. This has priority over a simultaneously accepted STOP; the STOP is consumed.
  - Otherwise an accepted STOP -> IDLE, resumable by a later RUN/STEP with the PC unchanged. RUN/STEP in RUN are no-ops.
- STEP: exactly one cycle with o_pc_hold=0, o_pipe_en=1, o_cmd_ready=0.
  - Next state is DRAIN (counter loaded) if i_halt_instr=1 in that cycle, else IDLE.
  - Therefore a STEP moves the PC by exactly one instruction or one jump target.
- DRAIN: o_pc_hold=1, o_pipe_en=1, o_if_flush=1, o_cmd_ready=0. i_halt_instr is ignored.
  - The counter decrements each cycle. When counter==1 -> DONE.
  - DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- DONE: o_pc_hold=1, o_pipe_en=0, o_running=0. o_cmd_ready=1; every command is accepted and ignored. Only reset leaves DONE.
- o_done: registered. It is 1 in the first cycle the state reads DONE, and 0 otherwise.
- o_cycle_count: increments on every rising edge where o_pipe_en=1 (RUN, STEP and DRAIN cycles). It holds at 2^CNT_W-1; no wrap.
- i_cmd value outside the accept window is don't-care. An illegal state register value recovers to IDLE on the next clock.
- The PC's own i_stall (hazard unit) is independent. This block does not observe it, and stalled cycles in RUN are still counted.

Decomposition:
- Shared package holds the command codes (CMD_NOP, CMD_RUN, CMD_STEP, CMD_STOP), the state encodings, and the default DRAIN_CYCLES, for reuse by the debug unit and the testbench.
- One natural sub-module: sat_counter (parameterised width, enable, synchronous clear, saturate at max), used for o_cycle_count.
- The drain counter stays inline.

Test Plan:
1. Reset, then RUN; i_halt_instr pulses high at cycle 10 after acceptance -> o_pc_hold=0 for cycles 1..10; DRAIN for 4 cycles with o_if_flush=1; o_done high for exactly one cycle; o_cycle_count=14; o_pipe_en=0 thereafter.
2. Three consecutive STEP commands from IDLE, no halt -> each produces one cycle of o_pc_hold=0 with o_cmd_ready=0 in that cycle; o_cycle_count=3; state returns to IDLE between steps.
3. RUN, then STOP after 5 cycles, then RUN again -> IDLE with o_pc_hold=1 during the pause; counter holds at 5 and resumes incrementing; no o_done.
4. In RUN, assert STOP and i_halt_instr in the same cycle -> state goes to DRAIN, not IDLE; DONE is reached after DRAIN_CYCLES.
5. Assert i_reset low two cycles into DRAIN -> asynchronously state=IDLE, o_cycle_count=0, o_done=0, o_pc_hold=1; a new RUN works normally.
6. CNT_W=4: RUN for 20 cycles -> o_cycle_count saturates at 15 and stays there. Also: commands issued in DONE are accepted (o_cmd_ready=1) with no state change.
